// File: rtl/demo_clk_pkg.sv
// Shared types and defaults for the picoMIPS clock/step generator.
// Contents:
//   mode_t            - encoding of the mode input (reserved value acts as HOLD)
//   DIV_W_DEFAULT     - prescaler width giving ~12 Hz RUN rate at 50 MHz
//   DEBOUNCE_DEFAULT  - stable-sample count for a 10 ms debounce at 50 MHz
package demo_clk_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  localparam int unsigned DIV_W_DEFAULT    = 22;
  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-count debouncer and a
// registered rising-edge detect of the debounced level.
// Ports:
//   fastclk     in  board clock, all state on its rising edge
//   n_reset     in  synchronous active-low reset
//   raw_in      in  raw asynchronous button level
//   level_out   out debounced level
//   rise_pulse  out one-cycle pulse, high in the cycle after level_out rises
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic fastclk,
  input  logic n_reset,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1;
  logic            s2;
  logic [CntW-1:0] cnt;

  always_ff @(posedge fastclk) begin
    if (!n_reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      level_out  <= 1'b0;
      cnt        <= '0;
      rise_pulse <= 1'b0;
    end else begin
      s1         <= raw_in;
      s2         <= s1;
      rise_pulse <= 1'b0;
      if (s2 == level_out) begin
        // Any disagreement run shorter than DEBOUNCE_CYCLES restarts here.
        cnt <= '0;
      end else if (cnt == CntMax) begin
        level_out  <= s2;
        cnt        <= '0;
        // Pulse is set on the same edge the level flips, so it is registered
        // yet visible one cycle after the level change.
        rise_pulse <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_step_gen.sv
// Single-cycle clock-enable generator for running picoMIPS at human speed.
// Modes: HOLD (no ticks), RUN (divided rate), STEP (one tick per debounced
// button press). Everything stays in the fastclk domain.
// Ports:
//   fastclk     in  board clock
//   n_reset     in  synchronous active-low reset
//   mode        in  00 HOLD, 01 RUN, 10 STEP, 11 reserved (HOLD)
//   rate_sel    in  RUN speed select, period = 2**(DIV_W - rate_sel)
//   step_btn    in  raw push-button, active high
//   tick        out registered one-cycle CPU enable
//   slow_clk    out visible square wave in RUN, 0 otherwise
//   tick_count  out wrapping count of issued ticks
//   running     out high while the registered mode is RUN
module clock_step_gen
  import demo_clk_pkg::*;
#(
  parameter int unsigned DIV_W           = DIV_W_DEFAULT,
  parameter int unsigned RATE_SEL_W      = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                  fastclk,
  input  logic                  n_reset,
  input  logic [1:0]            mode,
  input  logic [RATE_SEL_W-1:0] rate_sel,
  input  logic                  step_btn,
  output logic                  tick,
  output logic                  slow_clk,
  output logic [CNT_W-1:0]      tick_count,
  output logic                  running
);

  mode_t            mode_q;
  mode_t            mode_next;
  logic             mode_chg;
  logic [DIV_W-1:0] prescaler;
  logic [DIV_W-1:0] period_m1;
  logic [DIV_W-1:0] half_m1;
  logic             wrap;
  logic             step_rise;
  logic             unused_level;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .fastclk   (fastclk),
    .n_reset   (n_reset),
    .raw_in    (step_btn),
    .level_out (unused_level),
    .rise_pulse(step_rise)
  );

  always_comb begin
    mode_next = mode_t'(mode);
    mode_chg  = (mode_next != mode_q);
    // P-1 and P/2-1 as all-ones masks shifted by the rate select.
    period_m1 = {DIV_W{1'b1}} >> rate_sel;
    half_m1   = period_m1 >> 1;
    // >= so a mid-period speed-up wraps on the next edge instead of overrunning.
    wrap      = (prescaler >= period_m1);
  end

  always_ff @(posedge fastclk) begin
    if (!n_reset) begin
      mode_q     <= MODE_HOLD;
      prescaler  <= '0;
      tick       <= 1'b0;
      slow_clk   <= 1'b0;
      tick_count <= '0;
      running    <= 1'b0;
    end else begin
      mode_q     <= mode_next;
      running    <= (mode_next == MODE_RUN);
      tick_count <= tick_count + CNT_W'(tick);
      if (mode_chg) begin
        prescaler <= '0;
        tick      <= 1'b0;
        slow_clk  <= 1'b0;
      end else begin
        unique case (mode_q)
          MODE_RUN: begin
            tick      <= wrap;
            prescaler <= wrap ? '0 : prescaler + 1'b1;
            slow_clk  <= (prescaler <= half_m1);
          end
          MODE_STEP: begin
            tick      <= step_rise;
            prescaler <= '0;
            slow_clk  <= 1'b0;
          end
          default: begin
            tick      <= 1'b0;
            prescaler <= '0;
            slow_clk  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_step_gen.sv
// Directed self-checking bench for clock_step_gen with small parameters
// (DIV_W=6 -> P=64 at rate_sel=0, DEBOUNCE_CYCLES=4, CNT_W=4).
module tb_clock_step_gen;

  localparam int unsigned DIV_W      = 6;
  localparam int unsigned RATE_SEL_W = 2;
  localparam int unsigned DC         = 4;
  localparam int unsigned CNT_W      = 4;

  logic                  fastclk = 1'b0;
  logic                  n_reset;
  logic [1:0]            mode;
  logic [RATE_SEL_W-1:0] rate_sel;
  logic                  step_btn;
  logic                  tick;
  logic                  slow_clk;
  logic [CNT_W-1:0]      tick_count;
  logic                  running;

  int vectors     = 0;
  int miscompares = 0;

  clock_step_gen #(
    .DIV_W          (DIV_W),
    .RATE_SEL_W     (RATE_SEL_W),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CNT_W)
  ) dut (
    .fastclk   (fastclk),
    .n_reset   (n_reset),
    .mode      (mode),
    .rate_sel  (rate_sel),
    .step_btn  (step_btn),
    .tick      (tick),
    .slow_clk  (slow_clk),
    .tick_count(tick_count),
    .running   (running)
  );

  always #5 fastclk = ~fastclk;

  // Advance one rising edge, then settle away from it.
  task automatic cyc();
    @(posedge fastclk);
    #1;
  endtask

  task automatic do_reset();
    n_reset  = 1'b0;
    mode     = 2'b00;
    rate_sel = '0;
    step_btn = 1'b0;
    cyc();
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    n_reset  = 1'b0;
    mode     = 2'b01;
    rate_sel = '0;
    step_btn = 1'b0;
    cyc();
    cyc();
    vectors++;
    if (tick !== 1'b0) begin
      miscompares++; $display("FAIL reset_tick got %b want 0", tick);
    end
    vectors++;
    if (slow_clk !== 1'b0) begin
      miscompares++; $display("FAIL reset_slow_clk got %b want 0", slow_clk);
    end
    vectors++;
    if (tick_count !== 4'd0) begin
      miscompares++; $display("FAIL reset_tick_count got %0d want 0", tick_count);
    end
    vectors++;
    if (running !== 1'b0) begin
      miscompares++; $display("FAIL reset_running got %b want 0", running);
    end
  endtask

  task automatic test_run_rate0();
    logic exp_tick;
    logic exp_slow;
    do_reset();
    mode = 2'b01;
    cyc();
    vectors++;
    if (running !== 1'b1) begin
      miscompares++; $display("FAIL run0_running got %b want 1", running);
    end
    for (int k = 1; k <= 200; k++) begin
      cyc();
      exp_tick = (k % 64 == 0);
      exp_slow = (((k - 1) % 64) < 32);
      vectors++;
      if (tick !== exp_tick) begin
        miscompares++; $display("FAIL run0_tick k=%0d got %b want %b", k, tick, exp_tick);
      end
      vectors++;
      if (slow_clk !== exp_slow) begin
        miscompares++; $display("FAIL run0_slow k=%0d got %b want %b", k, slow_clk, exp_slow);
      end
    end
    vectors++;
    if (tick_count !== 4'd3) begin
      miscompares++; $display("FAIL run0_count got %0d want 3", tick_count);
    end
  endtask

  task automatic test_rate_change();
    logic exp_tick;
    do_reset();
    mode = 2'b01;
    cyc();
    for (int k = 1; k <= 64; k++) begin
      cyc();
      exp_tick = (k == 64);
      vectors++;
      if (tick !== exp_tick) begin
        miscompares++; $display("FAIL rate_first k=%0d got %b want %b", k, tick, exp_tick);
      end
    end
    // Prescaler restarted at 0; after 40 more edges it holds 40.
    for (int k = 1; k <= 40; k++) begin
      cyc();
      vectors++;
      if (tick !== 1'b0) begin
        miscompares++; $display("FAIL rate_pre k=%0d got %b want 0", k, tick);
      end
    end
    rate_sel = 2'd2;
    cyc();
    vectors++;
    if (tick !== 1'b1) begin
      miscompares++; $display("FAIL rate_wrap got %b want 1", tick);
    end
    for (int k = 1; k <= 32; k++) begin
      cyc();
      exp_tick = (k % 16 == 0);
      vectors++;
      if (tick !== exp_tick) begin
        miscompares++; $display("FAIL rate_p16 k=%0d got %b want %b", k, tick, exp_tick);
      end
    end
  endtask

  // Holds the button for 20 edges; tick expected on edge index 6 (j == 7).
  task automatic press_20(input string name);
    logic exp_tick;
    step_btn = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      cyc();
      exp_tick = (j == DC + 3);
      vectors++;
      if (tick !== exp_tick) begin
        miscompares++; $display("FAIL %s j=%0d got %b want %b", name, j, tick, exp_tick);
      end
    end
    step_btn = 1'b0;
  endtask

  task automatic low_10(input string name);
    for (int j = 1; j <= 10; j++) begin
      cyc();
      vectors++;
      if (tick !== 1'b0) begin
        miscompares++; $display("FAIL %s j=%0d got %b want 0", name, j, tick);
      end
    end
  endtask

  task automatic test_step();
    do_reset();
    mode = 2'b10;
    cyc();
    for (int j = 1; j <= 3; j++) begin
      cyc();
      vectors++;
      if (tick !== 1'b0 || slow_clk !== 1'b0) begin
        miscompares++;
        $display("FAIL step_idle j=%0d got tick=%b slow=%b want 0/0", j, tick, slow_clk);
      end
    end
    press_20("step_press1");
    low_10("step_release1");
    vectors++;
    if (tick_count !== 4'd1) begin
      miscompares++; $display("FAIL step_count1 got %0d want 1", tick_count);
    end
    step_btn = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      cyc();
      vectors++;
      if (tick !== 1'b0) begin
        miscompares++; $display("FAIL step_glitch_hi j=%0d got %b want 0", j, tick);
      end
    end
    step_btn = 1'b0;
    low_10("step_glitch_lo");
    press_20("step_press2");
    low_10("step_release2");
    vectors++;
    if (tick_count !== 4'd2) begin
      miscompares++; $display("FAIL step_count2 got %0d want 2", tick_count);
    end
  endtask

  task automatic test_mode_switch();
    logic exp_tick;
    do_reset();
    mode = 2'b01;
    cyc();
    for (int k = 1; k <= 94; k++) begin
      if (k == 10) step_btn = 1'b1;
      if (k == 20) step_btn = 1'b0;
      cyc();
      exp_tick = (k == 64);
      vectors++;
      if (tick !== exp_tick) begin
        miscompares++; $display("FAIL sw_run_btn k=%0d got %b want %b", k, tick, exp_tick);
      end
    end
    // Prescaler is now 30.
    mode = 2'b00;
    cyc();
    vectors++;
    if (tick !== 1'b0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_hold_enter got tick=%b run=%b want 0/0", tick, running);
    end
    for (int k = 1; k <= 100; k++) begin
      cyc();
      vectors++;
      if (tick !== 1'b0 || slow_clk !== 1'b0) begin
        miscompares++;
        $display("FAIL sw_hold k=%0d got tick=%b slow=%b want 0/0", k, tick, slow_clk);
      end
    end
    mode = 2'b01;
    cyc();
    vectors++;
    if (running !== 1'b1) begin
      miscompares++; $display("FAIL sw_rerun_running got %b want 1", running);
    end
    for (int k = 1; k <= 64; k++) begin
      cyc();
      exp_tick = (k == 64);
      vectors++;
      if (tick !== exp_tick) begin
        miscompares++; $display("FAIL sw_rerun k=%0d got %b want %b", k, tick, exp_tick);
      end
    end
    mode = 2'b11;
    for (int k = 1; k <= 70; k++) begin
      cyc();
      vectors++;
      if (tick !== 1'b0 || slow_clk !== 1'b0 || running !== 1'b0) begin
        miscompares++;
        $display("FAIL sw_rsvd k=%0d got tick=%b slow=%b run=%b want 0/0/0",
                 k, tick, slow_clk, running);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_tick;
    do_reset();
    mode = 2'b01;
    for (int k = 1; k <= 20; k++) cyc();
    step_btn = 1'b1;
    cyc();
    cyc();
    n_reset = 1'b0;
    mode    = 2'b10;
    cyc();
    vectors++;
    if (tick !== 1'b0 || slow_clk !== 1'b0 || tick_count !== 4'd0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_outputs got tick=%b slow=%b cnt=%0d run=%b want 0/0/0/0",
               tick, slow_clk, tick_count, running);
    end
    n_reset = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      exp_tick = (j == DC + 3);
      vectors++;
      if (tick !== exp_tick) begin
        miscompares++; $display("FAIL rstmid_tick j=%0d got %b want %b", j, tick, exp_tick);
      end
    end
    vectors++;
    if (tick_count !== 4'd1) begin
      miscompares++; $display("FAIL rstmid_count got %0d want 1", tick_count);
    end
    step_btn = 1'b0;
  endtask

  task automatic test_wrap();
    logic             exp_tick;
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    rate_sel = 2'd3;
    mode     = 2'b01;
    cyc();
    for (int k = 1; k <= 17 * 8 + 1; k++) begin
      cyc();
      exp_tick = (k % 8 == 0);
      vectors++;
      if (tick !== exp_tick) begin
        miscompares++; $display("FAIL wrap_tick k=%0d got %b want %b", k, tick, exp_tick);
      end
      if (k % 8 == 1) begin
        exp_cnt = 4'((k - 1) / 8);
        vectors++;
        if (tick_count !== exp_cnt) begin
          miscompares++;
          $display("FAIL wrap_count k=%0d got %0d want %0d", k, tick_count, exp_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_rate0();
    test_rate_change();
    test_step();
    test_mode_switch();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_step_gen.md
Name: clock_step_gen

Overview:
Parametrised successor to the demo slow-clock counter, for running picoMIPS at human speed on the DE-series board. It produces a single-cycle clock-enable `tick` in the fastclk domain rather than a derived clock. Three modes:
- RUN: divided rate, selectable at runtime.
- STEP: one tick per debounced button press.
- HOLD: no ticks.

It also drives a visible `slow_clk` square wave and a tick counter for the LEDs/7-seg. The CPU consumes `tick` as its enable, and the whole design stays on fastclk.

Parameters:
- DIV_W, 22, prescaler width; RUN period P = 2**(DIV_W - rate_sel) cycles (about 12 Hz at 50 MHz when rate_sel=0).
- RATE_SEL_W, 2, width of rate_sel; requires 2**RATE_SEL_W - 1 < DIV_W - 1.
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronised samples needed to accept a button level change (10 ms).
- CNT_W, 16, width of tick_count.

Ports:
- fastclk  in  1  board clock, 50 MHz; all logic is on its rising edge
- n_reset  in  1  synchronous, active-low reset
- mode  in  2  00 HOLD, 01 RUN, 10 STEP, 11 reserved (treated as HOLD)
- rate_sel  in  RATE_SEL_W  RUN speed select; larger values are faster
- step_btn  in  1  raw asynchronous push-button, active-high after board inversion
- tick  out  1  single-cycle CPU enable pulse, registered
- slow_clk  out  1  visible square wave in RUN; 0 otherwise
- tick_count  out  CNT_W  number of ticks issued, wraps
- running  out  1  high when the registered mode is RUN

Behaviour:
- Reset (n_reset=0 at an edge):
  - Outputs: tick=0, slow_clk=0, tick_count=0, running=0.
  - Internal state: prescaler=0, sync FFs=0, debounced level=0, debounce count=0, mode register=HOLD.
  - Reset mid-press: the debouncer restarts from level 0. A button still held after reset in STEP mode yields exactly one tick once debounced.
- Mode capture:
  - mode is registered every cycle.
  - When the registered mode changes, the prescaler clears to 0 and no tick is issued in that cycle.
- RUN:
  - The prescaler increments each cycle.
  - When prescaler >= P-1: tick<=1 and prescaler<=0. The >= comparison makes a rate_sel increase mid-period wrap on the next edge and never overrun.
  - slow_clk <= (prescaler < P/2), registered.
  - step_btn is ignored, but the debouncer keeps tracking it.
- STEP:
  - The prescaler is held at 0 and slow_clk=0.
  - On a rising edge of the debounced level, tick<=1 for exactly one cycle.
  - Holding the button produces no further ticks; release and re-press is required.
- HOLD/reserved: tick=0, slow_clk=0, prescaler held at 0.
- Debouncer:
  - step_btn passes through a 2-FF synchroniser (s1, s2).
  - If s2 equals the debounced level, the counter is 0.
  - Otherwise, when counter == DEBOUNCE_CYCLES-1 the level takes s2 and the counter resets to 0; else the counter increments.
  - Glitches shorter than DEBOUNCE_CYCLES samples never change the level.
- STEP latency: tick is high during the cycle after the (DEBOUNCE_CYCLES+2)-th edge following the edge that first samples step_btn=1.
- tick_count increments on every cycle where tick=1; 2**CNT_W-1 wraps to 0.
- running is registered: (registered mode == RUN).

Decomposition:
- Package demo_clk_pkg:
  - typedef enum logic [1:0] mode_t {MODE_HOLD=2'b00, MODE_RUN=2'b01, MODE_STEP=2'b10, MODE_RSVD=2'b11}
  - localparam defaults for DIV_W and DEBOUNCE_CYCLES
- One sub-module, btn_debounce:
  - parameter DEBOUNCE_CYCLES
  - ports fastclk, n_reset, raw_in, level_out, rise_pulse
  - contains the synchroniser, counter, and registered rising-edge detect
- The prescaler, mode logic and tick_count live in clock_step_gen.

Test Plan (simulate with DIV_W=6, RATE_SEL_W=2, DEBOUNCE_CYCLES=4, CNT_W=4):
1. Reset, then RUN with rate_sel=0 for 200 cycles:
   - tick every 64 cycles, 3 ticks total
   - slow_clk high for 32 cycles and low for 32 cycles
   - tick_count=3
2. RUN rate_sel=0; at prescaler=40 switch rate_sel=2 (P=16):
   - tick on the next edge (40 >= 15), then every 16 cycles
3. STEP, step_btn high for 20 cycles:
   - exactly one tick, appearing 6 edges after the first sampling edge
   - tick_count=1
   - a 3-cycle glitch produces no tick
   - a 2nd press after 10 low cycles produces the 2nd tick
4. Mode switching:
   - press in RUN gives no step tick
   - switch RUN->HOLD at prescaler=30 gives no ticks for 100 cycles
   - back to RUN, the next tick arrives 64 cycles after the mode register update
   - mode=11 behaves as HOLD
5. n_reset low for 1 cycle mid-RUN and mid-debounce:
   - all outputs are 0 on the next cycle
   - with STEP and button held through reset, one tick arrives 6 edges after release of reset
6. Issue 17 ticks in RUN:
   - tick_count sequence ... 14, 15, 0, 1
